// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the microRISC pipeline controller.
// Holds the controller FSM state encoding and the register-address width
// that the hazard comparator and the interface use.
package pipeline_ctrl_pkg;

  localparam int unsigned REG_AW = 3;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline-controller bus: hazard inputs from the ID/EX/MEM/WB stages and
// the write-enable / flush controls back to the PC and pipeline registers.
//   master : the pipeline datapath (drives hazard inputs, takes controls)
//   slave  : the controller (takes hazard inputs, drives controls)
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  import pipeline_ctrl_pkg::*;

  reg_addr_t          id_rs1;
  reg_addr_t          id_rs2;
  logic               id_uses_rs1;
  logic               id_uses_rs2;
  logic               ex_mem_read;
  reg_addr_t          ex_write_reg;
  logic               ex_branch_taken;
  logic               mem_req;
  logic               mem_ready;
  logic               wb_halt;

  logic               pc_write;
  logic               if_id_write;
  logic               if_id_flush;
  logic               id_ex_write;
  logic               id_ex_flush;
  logic               ex_mem_write;
  logic               mem_wb_flush;
  logic               halted;
  logic               mem_err;
  logic [CNT_W-1:0]   stall_count;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_mem_read, ex_write_reg, ex_branch_taken,
           mem_req, mem_ready, wb_halt,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, mem_wb_flush, halted, mem_err, stall_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_mem_read, ex_write_reg, ex_branch_taken,
           mem_req, mem_ready, wb_halt,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, mem_wb_flush, halted, mem_err, stall_count
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard comparator (purely combinational).
//   id_rs1/id_rs2, id_uses_rs1/id_uses_rs2 : ID-stage source operands
//   ex_mem_read, ex_write_reg              : EX-stage load and its destination
//   load_use_stall                         : ID needs a value still being loaded
// r0 is compared like any other register.
module pipeline_ctrl_hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  reg_addr_t id_rs1,
  input  reg_addr_t id_rs2,
  input  logic      id_uses_rs1,
  input  logic      id_uses_rs2,
  input  logic      ex_mem_read,
  input  reg_addr_t ex_write_reg,
  output logic      load_use_stall
);

  always_comb begin
    load_use_stall = ex_mem_read &&
                     ((id_uses_rs1 && (id_rs1 == ex_write_reg)) ||
                      (id_uses_rs2 && (id_rs2 == ex_write_reg)));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage microRISC pipeline.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : slave side of pipeline_ctrl_if; hazard inputs in, PC and
//                pipeline-register write/flush controls, halted, mem_err and
//                the stall-cycle counter out.
// Controls are combinational from state and inputs; state, the memory wait
// counter, mem_err and stall_count are registered.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  pipeline_ctrl_if.slave  bus
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  ctrl_state_e        state_q;
  logic [WAIT_W-1:0]  wait_cnt_q;
  logic [CNT_W-1:0]   stall_q;
  logic               mem_err_q;

  logic load_use_stall;
  logic mem_stall;

  logic pc_write_c, if_id_write_c, if_id_flush_c, id_ex_write_c;
  logic id_ex_flush_c, ex_mem_write_c, mem_wb_flush_c, halted_c;

  pipeline_ctrl_hazard_detect u_hazard_detect (
    .id_rs1         (bus.id_rs1),
    .id_rs2         (bus.id_rs2),
    .id_uses_rs1    (bus.id_uses_rs1),
    .id_uses_rs2    (bus.id_uses_rs2),
    .ex_mem_read    (bus.ex_mem_read),
    .ex_write_reg   (bus.ex_write_reg),
    .load_use_stall (load_use_stall)
  );

  assign mem_stall = bus.mem_req && !bus.mem_ready;

  always_comb begin
    pc_write_c     = 1'b1;
    if_id_write_c  = 1'b1;
    if_id_flush_c  = 1'b0;
    id_ex_write_c  = 1'b1;
    id_ex_flush_c  = 1'b0;
    ex_mem_write_c = 1'b1;
    mem_wb_flush_c = 1'b0;
    halted_c       = 1'b0;

    unique case (state_q)
      RUN, MEM_WAIT: begin
        // RUN: wb_halt lets WB commit with default controls. MEM_WAIT stalls on
        // mem_ready alone; once ready, it falls through to branch/load-use.
        if ((state_q == RUN) && bus.wb_halt) begin
          // defaults
        end else if ((state_q == RUN) ? mem_stall : !bus.mem_ready) begin
          pc_write_c     = 1'b0;
          if_id_write_c  = 1'b0;
          id_ex_write_c  = 1'b0;
          ex_mem_write_c = 1'b0;
          mem_wb_flush_c = 1'b1;
        end else if (bus.ex_branch_taken) begin
          if_id_flush_c = 1'b1;
          id_ex_flush_c = 1'b1;
        end else if (load_use_stall) begin
          pc_write_c    = 1'b0;
          if_id_write_c = 1'b0;
          id_ex_flush_c = 1'b1;
        end
      end
      default: begin
        pc_write_c     = 1'b0;
        if_id_write_c  = 1'b0;
        id_ex_write_c  = 1'b0;
        ex_mem_write_c = 1'b0;
        mem_wb_flush_c = 1'b1;
        halted_c       = 1'b1;
      end
    endcase

    // Hold every pipeline register still while reset is asserted.
    if (!rst_n) begin
      pc_write_c     = 1'b0;
      if_id_write_c  = 1'b0;
      if_id_flush_c  = 1'b0;
      id_ex_write_c  = 1'b0;
      id_ex_flush_c  = 1'b0;
      ex_mem_write_c = 1'b0;
      mem_wb_flush_c = 1'b0;
      halted_c       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      stall_q    <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      if (!pc_write_c && (state_q != HALT) && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end

      unique case (state_q)
        RUN: begin
          if (bus.wb_halt) begin
            state_q <= HALT;
          end else if (mem_stall) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= '0;
          end
        end
        MEM_WAIT: begin
          if (bus.mem_ready) begin
            state_q <= RUN;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_q   <= HALT;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: begin
          // HALT: left only through reset.
        end
      endcase
    end
  end

  assign bus.pc_write     = pc_write_c;
  assign bus.if_id_write  = if_id_write_c;
  assign bus.if_id_flush  = if_id_flush_c;
  assign bus.id_ex_write  = id_ex_write_c;
  assign bus.id_ex_flush  = id_ex_flush_c;
  assign bus.ex_mem_write = ex_mem_write_c;
  assign bus.mem_wb_flush = mem_wb_flush_c;
  assign bus.halted       = halted_c;
  assign bus.mem_err      = mem_err_q;
  assign bus.stall_count  = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (MEM_TIMEOUT=4).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_pipeline_ctrl;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  pipeline_ctrl_if #(.CNT_W(16)) bus ();

  pipeline_ctrl #(
    .MEM_TIMEOUT (4),
    .CNT_W       (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
  //  ex_mem_write, mem_wb_flush, halted, mem_err}
  localparam logic [8:0] O_RST   = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] O_DEF   = 9'b1_1_0_1_0_1_0_0_0;
  localparam logic [8:0] O_MEM   = 9'b0_0_0_0_0_0_1_0_0;
  localparam logic [8:0] O_LU    = 9'b0_0_0_1_1_1_0_0_0;
  localparam logic [8:0] O_BR    = 9'b1_1_1_1_1_1_0_0_0;
  localparam logic [8:0] O_HALT  = 9'b0_0_0_0_0_0_1_1_0;
  localparam logic [8:0] O_HERR  = 9'b0_0_0_0_0_0_1_1_1;

  function automatic logic [8:0] outs();
    return {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_write,
            bus.id_ex_flush, bus.ex_mem_write, bus.mem_wb_flush, bus.halted,
            bus.mem_err};
  endfunction

  task automatic chk_o(input string tag, input logic [8:0] exp);
    logic [8:0] got;
    got = outs();
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: outputs got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] exp);
    compared++;
    assert (bus.stall_count === exp) else begin
      mismatched++;
      $error("FAIL %s: stall_count got %0d expected %0d", tag, bus.stall_count, exp);
    end
  endtask

  // Advance one full cycle: returns 1 ns after the next falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_rs1          = '0;
    bus.id_rs2          = '0;
    bus.id_uses_rs1     = 1'b0;
    bus.id_uses_rs2     = 1'b0;
    bus.ex_mem_read     = 1'b0;
    bus.ex_write_reg    = '0;
    bus.ex_branch_taken = 1'b0;
    bus.mem_req         = 1'b0;
    bus.mem_ready       = 1'b0;
    bus.wb_halt         = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    idle();
    rst_n = 1'b0;
    #2;
    chk_o("reset_outs", O_RST);
    chk_cnt("reset_cnt", 16'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk_o("post_reset_default", O_DEF);

    // Memory wait: stall beats branch on entry; wb_halt ignored in MEM_WAIT.
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0; bus.ex_branch_taken = 1'b1;
    #1 chk_o("memwait_entry_beats_branch", O_MEM);
    tick();
    bus.ex_branch_taken = 1'b0; bus.wb_halt = 1'b1;
    #1 chk_o("memwait_c1_ignores_halt", O_MEM);
    tick();
    bus.wb_halt = 1'b0;
    #1 chk_o("memwait_c2", O_MEM);
    tick();
    bus.mem_ready = 1'b1;
    #1 chk_o("memwait_ready_default", O_DEF);
    tick();
    chk_cnt("memwait_cnt", 16'd3);
    bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
    #1 chk_o("memwait_back_in_run", O_DEF);
    tick();

    // Load-use on rs2.
    bus.ex_mem_read = 1'b1; bus.ex_write_reg = 3'd5;
    bus.id_rs2 = 3'd5; bus.id_uses_rs2 = 1'b1;
    #1 chk_o("loaduse_rs2", O_LU);
    tick();
    chk_cnt("loaduse_rs2_cnt", 16'd4);
    bus.id_uses_rs2 = 1'b0;
    #1 chk_o("loaduse_unused_rs2", O_DEF);
    tick();
    chk_cnt("loaduse_unused_cnt", 16'd4);
    // Load-use on rs1 against r0.
    bus.ex_write_reg = 3'd0; bus.id_rs1 = 3'd0; bus.id_uses_rs1 = 1'b1;
    #1 chk_o("loaduse_r0", O_LU);
    tick();
    chk_cnt("loaduse_r0_cnt", 16'd5);
    bus.ex_branch_taken = 1'b1;
    #1 chk_o("branch_beats_loaduse", O_BR);
    tick();
    chk_cnt("branch_cnt", 16'd5);
    idle();

    // Reset in the middle of a memory wait.
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    tick(); tick(); tick();
    chk_cnt("pre_reset_cnt", 16'd8);
    rst_n = 1'b0;
    #1 chk_o("midop_reset_outs", O_RST);
    chk_cnt("midop_reset_cnt", 16'd0);
    tick();
    idle();
    rst_n = 1'b1;
    #1 chk_o("midop_release_default", O_DEF);
    tick();
    chk_cnt("midop_release_cnt", 16'd0);

    // wb_halt beats a memory stall.
    bus.wb_halt = 1'b1; bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    #1 chk_o("halt_vs_stall_cycle", O_DEF);
    tick();
    chk_o("halted_no_err", O_HALT);
    chk_cnt("halted_cnt", 16'd0);
    tick();
    chk_cnt("halted_cnt_frozen", 16'd0);
    rst_n = 1'b0;
    tick();
    idle();
    rst_n = 1'b1;
    #1 chk_o("after_halt_reset", O_DEF);

    // Timeout: RUN entry plus four MEM_WAIT cycles, then HALT with mem_err.
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk_o($sformatf("timeout_stall_%0d", i), O_MEM);
      tick();
    end
    chk_o("timeout_halt_err", O_HERR);
    chk_cnt("timeout_cnt", 16'd5);
    bus.mem_req = 1'b0;
    tick();
    chk_o("timeout_sticky", O_HERR);
    chk_cnt("timeout_cnt_frozen", 16'd5);
    rst_n = 1'b0;
    #1 chk_o("timeout_reset_outs", O_RST);
    tick();
    rst_n = 1'b1;
    #1 chk_o("timeout_release_default", O_DEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard and sequencing controller for the 16-bit, 5-stage microRISC pipeline.
- Generates the write-enable and flush controls for the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Detects three hazard classes: load-use, taken branch, and multi-cycle data-memory wait.
- Owns the halt/error state machine and a stall-cycle performance counter.

Parameters:
- MEM_TIMEOUT, 255: maximum consecutive MEM_WAIT cycles with mem_ready low before a fatal memory error.
- CNT_W, 16: width of stall_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1  in  3  ID-stage source register 1.
- id_rs2  in  3  ID-stage source register 2.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_mem_read  in  1  EX-stage instruction is a load.
- ex_write_reg  in  3  EX-stage destination register.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- mem_req  in  1  MEM stage holds a valid load or store.
- mem_ready  in  1  data memory completes the access this cycle.
- wb_halt  in  1  HALT instruction is in WB.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID bubble insert.
- id_ex_write  out  1  ID/EX load enable.
- id_ex_flush  out  1  ID/EX bubble insert.
- ex_mem_write  out  1  EX/MEM load enable.
- mem_wb_flush  out  1  MEM/WB bubble insert.
- halted  out  1  core halted.
- mem_err  out  1  sticky memory-timeout error.
- stall_count  out  CNT_W  saturating count of cycles with pc_write=0 while not halted.

Behaviour:
- FSM states: RUN, MEM_WAIT, HALT.
- Control outputs are combinational from state and current inputs. Counters, mem_err and state are registered.
- Reset (rst_n=0, asynchronous):
  - state=RUN; wait_cnt=0; stall_count=0; mem_err=0.
  - While rst_n is low, all write/flush outputs are 0 and halted=0.
  - Reset during MEM_WAIT or HALT returns to RUN with all counters cleared.
- Default (no hazard): all *_write=1, all *_flush=0.
- RUN priority, highest first:
  1. wb_halt=1: this cycle is default (WB commits); next state HALT.
  2. mem_req=1 and mem_ready=0:
     - pc_write, if_id_write, id_ex_write, ex_mem_write = 0.
     - mem_wb_flush=1.
     - next state MEM_WAIT; wait_cnt cleared to 0.
  3. ex_branch_taken=1: pc_write=1, if_id_flush=1, id_ex_flush=1.
  4. Load-use: ex_mem_read=1 and ((id_uses_rs1 and id_rs1==ex_write_reg) or (id_uses_rs2 and id_rs2==ex_write_reg)):
     - pc_write=0, if_id_write=0, id_ex_flush=1; everything else default.
     - Applies to r0 as well; no special case.
- MEM_WAIT:
  - wb_halt is ignored (MEM/WB holds a bubble).
  - mem_ready=0:
    - same outputs as RUN case 2.
    - If wait_cnt==MEM_TIMEOUT-1: next state HALT and mem_err set. Otherwise wait_cnt increments.
  - mem_ready=1:
    - outputs evaluated exactly as RUN priorities 3–4 (the access completes, MEM/WB captures).
    - next state RUN.
- HALT:
  - pc_write, if_id_write, id_ex_write, ex_mem_write = 0; mem_wb_flush=1; halted=1.
  - Exit only via reset. mem_err holds.
- stall_count:
  - increments on each cycle with pc_write=0 in RUN or MEM_WAIT.
  - saturates at all-ones; does not count in HALT.
- Simultaneous events:
  - wb_halt beats a memory stall.
  - A memory stall beats a branch; the branch is re-evaluated when the stall releases, since EX is frozen.
  - A branch beats load-use; the ID instruction is squashed, so no stall is taken.
- Worked timeout example (MEM_TIMEOUT=4): the RUN entry cycle plus MEM_WAIT cycles with wait_cnt 0,1,2,3 give 5 stalled cycles. HALT and mem_err are visible on the following cycle.

Decomposition:
- Shared package/defines: FSM state encodings (RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2) and the 3-bit register-address width.
- Sub-module hazard_detect: purely combinational load-use comparator producing load_use_stall. Everything else stays in pipeline_ctrl.

Test Plan:
- Reset mid-operation: drive mem_req=1, mem_ready=0 for 3 cycles, then pulse rst_n low → state RUN, stall_count=0, mem_err=0, all outputs 0 while low, defaults after release.
- Load-use: ex_mem_read=1, ex_write_reg=3'd5, id_rs2=3'd5, id_uses_rs2=1 → pc_write=0, if_id_write=0, id_ex_flush=1, stall_count +1. Same stimulus with id_uses_rs2=0 → defaults.
- Branch plus load-use in the same cycle: ex_branch_taken=1 with the load-use condition above → pc_write=1, if_id_flush=1, id_ex_flush=1, stall_count unchanged.
- Memory wait: mem_req=1, mem_ready low for 3 cycles, then high →
  - 3 cycles with all writes 0 and mem_wb_flush=1.
  - the ready cycle has defaults.
  - state returns to RUN; stall_count=3.
- Timeout with MEM_TIMEOUT=4: mem_ready held low → after 5 stalled cycles, halted=1 and mem_err=1. Deasserting mem_req afterwards leaves both high until reset.
- Halt versus stall: wb_halt=1 with mem_req=1, mem_ready=0 in the same cycle → that cycle has defaults, next cycle halted=1, mem_err=0, stall_count frozen.
